// File: rtl/spart_pkg.sv
// Shared SPART definitions: MMIO window, default bus widths and the queued write record.
package spart_pkg;

    localparam logic [31:0] SPART_MMIO_BASE = 32'hC000_0000;
    localparam logic [31:0] SPART_MMIO_MASK = 32'hFFFF_FF00;
    localparam int          SPART_DATA_W    = 32;
    localparam int          SPART_ADDR_W    = 32;

    typedef struct packed {
        logic [SPART_ADDR_W-1:0] addr;
        logic [SPART_DATA_W-1:0] data;
    } spart_wr_t;

endpackage

// File: rtl/spart_wr_queue_mem.sv
// Write-queue storage: one synchronous write port, one asynchronous read port, no reset.
module spart_wr_queue_mem
    import spart_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = spart_wr_t,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  entry_t           wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output entry_t           rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read is combinational so the head entry falls through to the consumer.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spart_wr_queue.sv
// FWFT write queue from the CPU SPART write port to the transmitter, with
// almost-full stall hint, saturating overflow counter and flush on switch_program.
module spart_wr_queue
    import spart_pkg::*;
#(
    parameter int                DATA_W    = SPART_DATA_W,
    parameter int                ADDR_W    = SPART_ADDR_W,
    parameter int                DEPTH     = 8,
    parameter int                AF_MARGIN = 2,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(SPART_MMIO_BASE),
    parameter logic [ADDR_W-1:0] MMIO_MASK = ADDR_W'(SPART_MMIO_MASK),
    parameter int                OVF_W     = 8,
    localparam int               PTR_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch_program,
    input  logic              spart_wrt_en,
    input  logic [ADDR_W-1:0] spart_wrt_add,
    input  logic [DATA_W-1:0] spart_wrt_data,
    output logic              cpu_stall,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] tx_addr,
    output logic [DATA_W-1:0] tx_data,
    output logic [PTR_W-1:0]  count,
    output logic [OVF_W-1:0]  ovf_cnt
);

    localparam int IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] STALL_C = PTR_W'(DEPTH - AF_MARGIN);
    localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             stall_q, stall_d;

    logic   hit, full, empty, push, pop, drop;
    entry_t wr_entry, head;

    assign hit   = spart_wrt_en && ((spart_wrt_add & MMIO_MASK) == MMIO_BASE);
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Flush wins over everything; a dropped write is only counted outside a flush.
    assign push = hit && !full && !switch_program;
    assign drop = hit &&  full && !switch_program;
    assign pop  = !empty && tx_ready && !switch_program;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        stall_d  = 1'b0;
        if (switch_program) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE_C;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE_C;
            if (push && !pop) count_d = count_q + ONE_C;
            else if (pop && !push) count_d = count_q - ONE_C;
            if (drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
            stall_d = (count_d >= STALL_C);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            stall_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            stall_q  <= stall_d;
        end
    end

    assign wr_entry = '{addr: spart_wrt_add, data: spart_wrt_data};

    spart_wr_queue_mem #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[IDX_W-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[IDX_W-1:0]),
        .rdata_o (head)
    );

    assign tx_valid  = !empty;
    assign tx_addr   = head.addr;
    assign tx_data   = head.data;
    assign count     = count_q;
    assign ovf_cnt   = ovf_q;
    assign cpu_stall = stall_q;

endmodule

// File: tb/tb_spart_wr_queue.sv
// Self-checking bench for spart_wr_queue against a queue-based reference model.
module tb_spart_wr_queue;

    localparam int DEPTH = 8;
    localparam int AF    = 2;
    localparam logic [31:0] BASE = 32'hC000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        switch_program = 1'b0;
    logic        spart_wrt_en = 1'b0;
    logic [31:0] spart_wrt_add = '0;
    logic [31:0] spart_wrt_data = '0;
    logic        cpu_stall;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_addr;
    logic [31:0] tx_data;
    logic [3:0]  count;
    logic [7:0]  ovf_cnt;

    always #5 clk = ~clk;

    spart_wr_queue dut (
        .clk(clk), .rst(rst), .switch_program(switch_program),
        .spart_wrt_en(spart_wrt_en), .spart_wrt_add(spart_wrt_add),
        .spart_wrt_data(spart_wrt_data), .cpu_stall(cpu_stall),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_addr(tx_addr),
        .tx_data(tx_data), .count(count), .ovf_cnt(ovf_cnt)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   movf   = 0;
    bit   mstall = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // One clock of stimulus; the model advances by the behavioural rules.
    task automatic cyc(input logic en, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic sp, input logic r);
        bit hit, was_full, was_busy;
        ent_t e;
        spart_wrt_en = en; spart_wrt_add = a; spart_wrt_data = d;
        tx_ready = rdy; switch_program = sp; rst = r;
        hit = en && ((a & MASK) == BASE);
        if (r) begin
            mq.delete(); movf = 0;
        end else if (sp) begin
            mq.delete();
        end else begin
            was_full = (mq.size() == DEPTH);
            was_busy = (mq.size() != 0);
            if (hit && was_full && movf < 255) movf++;
            if (was_busy && rdy) void'(mq.pop_front());
            if (hit && !was_full) begin
                e.a = a; e.d = d; mq.push_back(e);
            end
        end
        mstall = !r && !sp && (mq.size() >= DEPTH - AF);
        @(posedge clk); #1;
        spart_wrt_en = 1'b0; tx_ready = 1'b0; switch_program = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", tx_valid); end
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovf got %0d want 0", ovf_cnt); end
        n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
    endtask

    task automatic test_single();
        cyc(1, 32'hC000_0004, 32'hDEAD_BEEF, 0, 0, 0);
        n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", tx_valid); end
        n_tests++; if (tx_addr !== 32'hC000_0004) begin n_fail++; $display("FAIL single_addr got %h want C0000004", tx_addr); end
        n_tests++; if (tx_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data got %h want DEADBEEF", tx_data); end
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
        cyc(0, 0, 0, 1, 0, 0);
        n_tests++; if (tx_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL single_pop got valid=%b count=%0d want 0/0", tx_valid, count); end
        cyc(0, 0, 0, 1, 0, 0);
        n_tests++; if (tx_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL ready_empty got valid=%b count=%0d want 0/0", tx_valid, count); end
    endtask

    task automatic test_filter();
        cyc(1, 32'h0000_1000, 32'h1111_2222, 0, 0, 0);
        n_tests++; if (count !== 4'd0 || tx_valid !== 1'b0 || ovf_cnt !== 8'd0) begin
            n_fail++; $display("FAIL filter got count=%0d valid=%b ovf=%0d want 0/0/0", count, tx_valid, ovf_cnt);
        end
        cyc(1, 32'hC000_0100, 32'h3, 0, 0, 0);
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL filter_edge got count=%0d want 0", count); end
    endtask

    task automatic test_fill_overflow();
        int exp_c;
        for (int i = 1; i <= 10; i++) begin
            cyc(1, BASE + 32'(4 * i), 32'(i), 0, 0, 0);
            exp_c = (i > DEPTH) ? DEPTH : i;
            n_tests++; if (count !== 4'(exp_c)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, exp_c); end
            n_tests++; if (cpu_stall !== (exp_c >= 6)) begin n_fail++; $display("FAIL fill_stall[%0d] got %b want %b", i, cpu_stall, exp_c >= 6); end
        end
        n_tests++; if (ovf_cnt !== 8'd2) begin n_fail++; $display("FAIL fill_ovf got %0d want 2", ovf_cnt); end
        for (int k = 1; k <= DEPTH; k++) begin
            n_tests++; if (tx_valid !== 1'b1 || tx_data !== 32'(k)) begin
                n_fail++; $display("FAIL drain[%0d] got valid=%b data=%0d want 1/%0d", k, tx_valid, tx_data, k);
            end
            cyc(0, 0, 0, 1, 0, 0);
        end
        n_tests++; if (tx_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL drain_end got valid=%b count=%0d want 0/0", tx_valid, count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            cyc(1, BASE + 32'h40, 32'h100 + 32'(i), 1, 0, 0);
            n_tests++; if (count !== 4'd1 || tx_data !== 32'h100 + 32'(i)) begin
                n_fail++; $display("FAIL wrap[%0d] got count=%0d data=%h want 1/%h", i, count, tx_data, 32'h100 + 32'(i));
            end
        end
        cyc(0, 0, 0, 1, 0, 0);
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL wrap_end got count=%0d want 0", count); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < DEPTH; i++) cyc(1, BASE, 32'(50 + i), 0, 0, 0);
        cyc(1, BASE, 32'h99, 1, 0, 0);
        n_tests++; if (count !== 4'd7 || ovf_cnt !== 8'd3) begin
            n_fail++; $display("FAIL full_pop got count=%0d ovf=%0d want 7/3", count, ovf_cnt);
        end
        cyc(1, BASE, 32'h77, 0, 0, 0);
        n_tests++; if (count !== 4'd8 || ovf_cnt !== 8'd3) begin
            n_fail++; $display("FAIL full_reuse got count=%0d ovf=%0d want 8/3", count, ovf_cnt);
        end
        cyc(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cyc(1, BASE, 32'(i), 0, 0, 0);
        n_tests++; if (count !== 4'd5 || ovf_cnt !== 8'd3) begin n_fail++; $display("FAIL flush_pre got count=%0d ovf=%0d want 5/3", count, ovf_cnt); end
        cyc(1, BASE, 32'hBAD, 1, 1, 0);
        n_tests++; if (count !== 4'd0 || tx_valid !== 1'b0 || cpu_stall !== 1'b0 || ovf_cnt !== 8'd3) begin
            n_fail++; $display("FAIL flush got count=%0d valid=%b stall=%b ovf=%0d want 0/0/0/3", count, tx_valid, cpu_stall, ovf_cnt);
        end
        cyc(1, BASE + 32'h10, 32'h1234, 0, 0, 0);
        n_tests++; if (tx_valid !== 1'b1 || tx_data !== 32'h1234 || tx_addr !== BASE + 32'h10) begin
            n_fail++; $display("FAIL flush_after got valid=%b addr=%h data=%h want 1/C0000010/1234", tx_valid, tx_addr, tx_data);
        end
        cyc(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_ovf_sat();
        for (int i = 0; i < DEPTH + 260; i++) cyc(1, BASE, 32'(i), 0, 0, 0);
        n_tests++; if (ovf_cnt !== 8'hFF) begin n_fail++; $display("FAIL ovf_sat got %0d want 255", ovf_cnt); end
        cyc(0, 0, 0, 0, 0, 1);
        n_tests++; if (ovf_cnt !== 8'd0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got ovf=%0d valid=%b want 0/0", ovf_cnt, tx_valid); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 3) != 0) ? (BASE | 32'($urandom_range(0, 255))) : $urandom;
            cyc($urandom_range(0, 3) != 0, a, $urandom, $urandom_range(0, 2) == 0,
                $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
            n_tests++; if (count !== 4'(mq.size()) || tx_valid !== (mq.size() != 0) ||
                           ovf_cnt !== 8'(movf) || cpu_stall !== mstall) begin
                n_fail++; $display("FAIL rand_ctl[%0d] got count=%0d valid=%b ovf=%0d stall=%b want %0d/%b/%0d/%b",
                                   i, count, tx_valid, ovf_cnt, cpu_stall, mq.size(), mq.size() != 0, movf, mstall);
            end
            if (mq.size() != 0) begin
                n_tests++; if (tx_addr !== mq[0].a || tx_data !== mq[0].d) begin
                    n_fail++; $display("FAIL rand_head[%0d] got %h/%h want %h/%h", i, tx_addr, tx_data, mq[0].a, mq[0].d);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_filter();
        test_fill_overflow();
        test_wrap();
        test_full_pop();
        test_flush();
        test_ovf_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
